// File: rtl/clock_enable_gen.sv
// Programmable clock-enable generator: free-running phase counter with a
// registered tick strobe, a square-wave output and glitch-free divisor updates.
module clock_enable_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_54mhz,
  input  logic             restart,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] phase,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_WIDE  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] div_pending;
  logic [WIDTH-1:0] phase_nxt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   high_count;
  logic             wrap;

  // High-phase length is computed one bit wider so N = 2^WIDTH-1 cannot overflow.
  always_comb begin
    wrap       = enable && (phase == (div_active - ONE));
    phase_nxt  = wrap ? '0 : (phase + ONE);
    load_val   = (div_value == '0) ? ONE : div_value;
    high_count = ({1'b0, div_active} + ONE_WIDE) >> 1;
  end

  always_ff @(posedge clk_54mhz) begin
    if (restart) begin
      phase        <= '0;
      tick         <= 1'b0;
      clk_out      <= 1'b0;
      div_active   <= DIV_RESET;
      div_pending  <= DIV_RESET;
      load_pending <= 1'b0;
    end else begin
      tick <= wrap;
      if (enable) begin
        phase   <= phase_nxt;
        clk_out <= ({1'b0, phase_nxt} < high_count);
      end
      // A new divisor only ever takes effect on a wrap edge, so no period is cut short.
      if (wrap) begin
        load_pending <= 1'b0;
        if (div_load) begin
          div_active  <= load_val;
          div_pending <= load_val;
        end else if (load_pending) begin
          div_active <= div_pending;
        end
      end else if (div_load) begin
        div_pending  <= load_val;
        load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_clock_enable_gen;

  logic       clk_54mhz = 1'b0;
  logic       restart = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] div_value = '0;
  logic       div_load = 1'b0;
  logic       tick;
  logic       clk_out;
  logic [7:0] phase;
  logic [7:0] div_active;
  logic       load_pending;

  clock_enable_gen dut (
    .clk_54mhz    (clk_54mhz),
    .restart      (restart),
    .enable       (enable),
    .div_value    (div_value),
    .div_load     (div_load),
    .tick         (tick),
    .clk_out      (clk_out),
    .phase        (phase),
    .div_active   (div_active),
    .load_pending (load_pending)
  );

  always #5 clk_54mhz = ~clk_54mhz;

  typedef struct {
    int tick;
    int clk_out;
    int phase;
    int div;
    int lp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int m_phase = 0, m_div = 2, m_pend = 2, m_lp = 0, m_tick = 0, m_clk = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] v);
    exp_t x;
    int   ldv;
    bit   w;
    @(negedge clk_54mhz);
    restart   = r;
    enable    = e;
    div_load  = l;
    div_value = v;
    if (r) begin
      m_phase = 0; m_tick = 0; m_clk = 0; m_div = 2; m_pend = 2; m_lp = 0;
    end else begin
      ldv = (v == 0) ? 1 : int'(v);
      w   = e && (m_phase == m_div - 1);
      m_tick = w;
      if (e) begin
        m_phase = w ? 0 : m_phase + 1;
        m_clk   = (m_phase < (m_div + 1) / 2);
      end
      if (w) begin
        if (l) m_div = ldv;
        else if (m_lp != 0) m_div = m_pend;
        if (l) m_pend = ldv;
        m_lp = 0;
      end else if (l) begin
        m_pend = ldv;
        m_lp   = 1;
      end
    end
    x.tick = m_tick; x.clk_out = m_clk; x.phase = m_phase; x.div = m_div; x.lp = m_lp;
    exp_q.push_back(x);
    @(posedge clk_54mhz);
    #1;
    x = exp_q.pop_front();
    chk("sb_tick", int'(tick), x.tick);
    chk("sb_clk_out", int'(clk_out), x.clk_out);
    chk("sb_phase", int'(phase), x.phase);
    chk("sb_div_active", int'(div_active), x.div);
    chk("sb_load_pending", int'(load_pending), x.lp);
  endtask

  initial begin
    int n;
    step(1, 0, 0, 0);
    step(1, 1, 1, 9);
    chk("rst_phase", int'(phase), 0);
    chk("rst_div", int'(div_active), 2);
    chk("rst_lp", int'(load_pending), 0);

    // Default divide-by-2: tick and clk_out alternate 0,1,0,1
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      chk("div2_tick", int'(tick), i % 2);
      chk("div2_clk", int'(clk_out), i % 2);
    end

    // Load 5; then check the 1,1,1,0,0 pattern over two periods
    step(0, 1, 1, 5);
    chk("n5_lp_set", int'(load_pending), 1);
    n = 0;
    while (!(m_div == 5 && m_phase == 0) && n < 20) begin step(0, 1, 0, 0); n++; end
    chk("n5_applied", int'(div_active), 5);
    for (int i = 1; i < 11; i++) begin
      step(0, 1, 0, 0);
      chk("n5_clk", int'(clk_out), ((i % 5) < 3) ? 1 : 0);
      chk("n5_tick", int'(tick), ((i % 5) == 0) ? 1 : 0);
    end

    // Overwrite pending value before the wrap: 3 is never used
    n = 0;
    while (m_phase != 2 && n < 20) begin step(0, 1, 0, 0); n++; end
    chk("req33_reach", int'(phase), 2);
    step(0, 1, 1, 3);
    step(0, 1, 1, 7);
    chk("req33_still5", int'(div_active), 5);
    step(0, 1, 0, 0);
    chk("req33_div7", int'(div_active), 7);
    chk("req33_lp", int'(load_pending), 0);
    chk("req33_tick", int'(tick), 1);

    // Load coincident with wrap takes effect immediately
    n = 0;
    while (m_phase != m_div - 1 && n < 20) begin step(0, 1, 0, 0); n++; end
    chk("req34_reach", int'(phase), 6);
    step(0, 1, 1, 4);
    chk("req34_div4", int'(div_active), 4);
    chk("req34_lp", int'(load_pending), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("req34_notick", int'(tick), 0);
      chk("req34_lp_low", int'(load_pending), 0);
    end
    step(0, 1, 0, 0);
    chk("req34_tick4", int'(tick), 1);

    // Divisor 0 becomes 1; then pause
    step(0, 1, 1, 0);
    n = 0;
    while (m_div != 1 && n < 20) begin step(0, 1, 0, 0); n++; end
    chk("req35_div1", int'(div_active), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("req35_tick", int'(tick), 1);
      chk("req35_clk", int'(clk_out), 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("req35_hold_tick", int'(tick), 0);
      chk("req35_hold_phase", int'(phase), 0);
      chk("req35_hold_clk", int'(clk_out), 1);
    end

    // Restart mid-period with a pending load, restart beats enable and div_load
    step(0, 1, 1, 6);
    chk("req36_div6", int'(div_active), 6);
    n = 0;
    while (m_phase != 1 && n < 20) begin step(0, 1, 0, 0); n++; end
    step(0, 1, 1, 9);
    step(0, 1, 0, 0);
    chk("req36_phase3", int'(phase), 3);
    chk("req36_lp1", int'(load_pending), 1);
    step(0, 0, 0, 0);
    chk("req36_pend_hold", int'(load_pending), 1);
    step(1, 1, 1, 5);
    chk("req36_phase", int'(phase), 0);
    chk("req36_tick", int'(tick), 0);
    chk("req36_clk", int'(clk_out), 0);
    chk("req36_div", int'(div_active), 2);
    chk("req36_lp", int'(load_pending), 0);

    // Random traffic, all checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 40) == 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
